// File: rtl/game_session_controller.sv
// Purpose : runs one player session per authenticator login; saves the final score and issues the logout handshake.
// Latency : game_enable rises 1 cycle after LoggedIn is sampled; score_we 1 cycle after game_over/logout_button; LogoutCommand 1 cycle later.
// Backpres: none; LogoutCommand is re-pulsed every RETRY_CYCLES cycles until LoggedOut is seen.
//
// Ports: clk/rst (synchronous, active-high), sec_tick, authenticator handshake (LoggedIn, LoggedOut, isGuest,
//        PlayerAddress, LogoutCommand), user/game events (activity, logout_button, game_over, score), score memory
//        port (score_addr, score_we, score_wdata, best_score), status (game_enable, session_guest, timeout_flag).
// Option : define HIGH_SCORE_EN to write the score only when it beats best_score.
module game_session_controller #(
    parameter int INACTIVITY_SECS = 30,
    parameter int SCORE_W         = 8,
    parameter int RETRY_CYCLES    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sec_tick,
    input  logic               LoggedIn,
    input  logic               LoggedOut,
    input  logic               isGuest,
    input  logic [4:0]         PlayerAddress,
    input  logic               activity,
    input  logic               logout_button,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] best_score,
    output logic               LogoutCommand,
    output logic               game_enable,
    output logic               session_guest,
    output logic [4:0]         score_addr,
    output logic               score_we,
    output logic [SCORE_W-1:0] score_wdata,
    output logic               timeout_flag
);

    localparam int IDLE_W  = $clog2(INACTIVITY_SECS + 1);
    localparam int RETRY_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        SAVE,
        LOGOUT,
        WAIT_OUT
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [IDLE_W-1:0]  idleCnt;
    logic [RETRY_W-1:0] retryCnt;
    logic               latchSession;
    logic               latchScore;
    logic               setTimeout;
    logic               retryWrap;
    logic               saveAllowed;

`ifdef HIGH_SCORE_EN
    assign saveAllowed = (score_wdata > best_score);
`else
    assign saveAllowed = 1'b1;
    logic unusedBestScore;
    assign unusedBestScore = ^best_score;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        game_enable   = 1'b0;
        score_we      = 1'b0;
        LogoutCommand = 1'b0;
        latchSession  = 1'b0;
        latchScore    = 1'b0;
        setTimeout    = 1'b0;
        retryWrap     = 1'b0;
        case (state)
            IDLE: begin
                if (LoggedIn) begin
                    latchSession = 1'b1;
                    nextState    = ACTIVE;
                end
            end
            ACTIVE: begin
                game_enable = 1'b1;
                // Authenticator-side drop wins over everything: nothing to save or acknowledge.
                if (!LoggedIn) begin
                    nextState = IDLE;
                end else if (logout_button || game_over) begin
                    latchScore = 1'b1;
                    nextState  = session_guest ? LOGOUT : SAVE;
                end else if (idleCnt == IDLE_W'(INACTIVITY_SECS)) begin
                    setTimeout = 1'b1;
                    nextState  = LOGOUT;
                end
            end
            SAVE: begin
                score_we  = saveAllowed;
                nextState = LOGOUT;
            end
            LOGOUT: begin
                LogoutCommand = 1'b1;
                nextState     = WAIT_OUT;
            end
            WAIT_OUT: begin
                // LoggedIn is deliberately ignored here; only the logout acknowledge ends the session.
                if (LoggedOut) begin
                    nextState = IDLE;
                end else if (retryCnt == RETRY_W'(RETRY_CYCLES - 1)) begin
                    LogoutCommand = 1'b1;
                    retryWrap     = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
        // Reset is synchronous, so the decoded strobes must be masked on the reset cycle itself.
        if (rst) begin
            game_enable   = 1'b0;
            score_we      = 1'b0;
            LogoutCommand = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt       <= '0;
            retryCnt      <= '0;
            score_addr    <= '0;
            session_guest <= 1'b0;
            score_wdata   <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            if (latchSession) begin
                score_addr    <= PlayerAddress;
                session_guest <= isGuest;
                timeout_flag  <= 1'b0;
                idleCnt       <= '0;
            end else if (state == ACTIVE) begin
                // Activity wins over a coincident tick; the counter saturates at the timeout value.
                if (activity) begin
                    idleCnt <= '0;
                end else if (sec_tick && (idleCnt != IDLE_W'(INACTIVITY_SECS))) begin
                    idleCnt <= idleCnt + IDLE_W'(1);
                end
            end
            if (latchScore) begin
                score_wdata <= score;
            end
            if (setTimeout) begin
                timeout_flag <= 1'b1;
            end
            if (state == LOGOUT) begin
                retryCnt <= '0;
            end else if ((state == WAIT_OUT) && !LoggedOut) begin
                retryCnt <= retryWrap ? '0 : retryCnt + RETRY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_session_controller.sv
// Purpose : randomized session-level stimulus for game_session_controller, checked against expected session outcomes.
// Latency : outputs observed on the falling edge; inputs change 1 time unit after the rising edge.
// Backpres: the bench models the authenticator and answers LogoutCommand with LoggedOut at chosen times.
module tb_game_session_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       LoggedIn = 1'b0;
    logic       LoggedOut = 1'b0;
    logic       isGuest = 1'b0;
    logic [4:0] PlayerAddress = '0;
    logic       activity = 1'b0;
    logic       logout_button = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] score = '0;
    logic [7:0] best_score = '0;
    logic       LogoutCommand;
    logic       game_enable;
    logic       session_guest;
    logic [4:0] score_addr;
    logic       score_we;
    logic [7:0] score_wdata;
    logic       timeout_flag;

    game_session_controller #(
        .INACTIVITY_SECS(30),
        .SCORE_W        (8),
        .RETRY_CYCLES   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sec_tick     (sec_tick),
        .LoggedIn     (LoggedIn),
        .LoggedOut    (LoggedOut),
        .isGuest      (isGuest),
        .PlayerAddress(PlayerAddress),
        .activity     (activity),
        .logout_button(logout_button),
        .game_over    (game_over),
        .score        (score),
        .best_score   (best_score),
        .LogoutCommand(LogoutCommand),
        .game_enable  (game_enable),
        .session_guest(session_guest),
        .score_addr   (score_addr),
        .score_we     (score_we),
        .score_wdata  (score_wdata),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event recorder: counts memory writes and logout pulses seen on the falling edge.
    int         cycleNo = 0;
    int         weCount = 0;
    int         lcCount = 0;
    int         lastWeCycle = 0;
    logic [4:0] lastAddr = '0;
    logic [7:0] lastData = '0;
    int         lcTimes[$];

    always @(negedge clk) begin
        cycleNo++;
        if (score_we) begin
            weCount++;
            lastWeCycle = cycleNo;
            lastAddr    = score_addr;
            lastData    = score_wdata;
        end
        if (LogoutCommand) begin
            lcCount++;
            lcTimes.push_back(cycleNo);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        sec_tick      = 1'b0;
        activity      = 1'b0;
        logout_button = 1'b0;
        game_over     = 1'b0;
    endtask

    function automatic bit expectWrite(input logic g, input logic [7:0] sc, input logic [7:0] best);
        if (g) return 1'b0;
`ifdef HIGH_SCORE_EN
        return sc > best;
`else
        return 1'b1;
`endif
    endfunction

    task automatic login(input logic [4:0] a, input logic g);
        PlayerAddress = a;
        isGuest       = g;
        LoggedIn      = 1'b1;
        LoggedOut     = 1'b0;
        #1;
        checkVal("en_before_login", game_enable, 0);
        cycle();
        checkVal("en_after_login", game_enable, 1);
        checkVal("addr_latched", score_addr, a);
        checkVal("guest_latched", session_guest, g);
        checkVal("tflag_clear_on_login", timeout_flag, 0);
        PlayerAddress = ~a;
        isGuest       = ~g;
    endtask

    task automatic finishLogout();
        LoggedOut = 1'b1;
        LoggedIn  = 1'b0;
        cycle();
        checkVal("en_idle", game_enable, 0);
        LoggedOut = 1'b0;
        cycle();
    endtask

    task automatic playSession(input logic [4:0] a, input logic g, input logic [7:0] sc,
                               input logic [7:0] best, input logic useGo);
        int we0;
        int lc0;
        bit expWr;
        login(a, g);
        repeat ($urandom_range(1, 10)) begin
            activity = 1'($urandom % 2);
            cycle();
        end
        score      = sc;
        best_score = best;
        we0        = weCount;
        lc0        = lcCount;
        if (useGo) game_over = 1'b1;
        else logout_button = 1'b1;
        cycle();
        score = ~sc;
        cycle();
        cycle();
        expWr = expectWrite(g, sc, best);
        checkVal("write_count", weCount - we0, 32'(expWr));
        if (expWr) begin
            checkVal("write_addr", lastAddr, a);
            checkVal("write_data", lastData, sc);
            checkVal("write_then_logout", lcTimes[$] - lastWeCycle, 1);
        end
        checkVal("logout_count", lcCount - lc0, 1);
        checkVal("en_in_wait", game_enable, 0);
        finishLogout();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int we0;
        int lc0;
        int c;
        int t0;
        int tEnd;
        int nExp;
        int k0;
        bit expTo;

        cycle();
        cycle();
        rst = 1'b0;
        checkVal("rst_en", game_enable, 0);
        checkVal("rst_we", score_we, 0);
        checkVal("rst_lc", LogoutCommand, 0);
        checkVal("rst_addr", score_addr, 0);
        checkVal("rst_guest", session_guest, 0);
        checkVal("rst_wdata", score_wdata, 0);
        checkVal("rst_tflag", timeout_flag, 0);
        cycle();

        // Directed examples, then random sessions.
        playSession(5'd7, 1'b0, 8'd42, 8'd0, 1'b1);
        playSession(5'd3, 1'b1, 8'd99, 8'd0, 1'b0);
        playSession(5'd9, 1'b0, 8'd40, 8'd50, 1'b1);
        playSession(5'd9, 1'b0, 8'd60, 8'd50, 1'b0);
        playSession(5'd11, 1'b0, 8'd50, 8'd50, 1'b0);
        repeat (8) begin
            playSession(5'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Exactly 30 idle ticks force a timeout; 29 do not.
        login(5'd4, 1'b0);
        we0 = weCount;
        lc0 = lcCount;
        for (int i = 1; i <= 30; i++) begin
            sec_tick = 1'b1;
            cycle();
            if (i == 29) begin
                repeat (3) cycle();
                checkVal("no_timeout_29", game_enable, 1);
                checkVal("no_tflag_29", timeout_flag, 0);
            end else if (i < 29) begin
                repeat ($urandom_range(0, 2)) cycle();
            end
        end
        cycle();
        cycle();
        cycle();
        checkVal("tflag_set", timeout_flag, 1);
        checkVal("timeout_no_write", weCount - we0, 0);
        checkVal("timeout_logout", lcCount - lc0, 1);
        checkVal("timeout_en", game_enable, 0);
        finishLogout();
        checkVal("tflag_sticky", timeout_flag, 1);

        // Activity on every 29th tick keeps the session alive across 100 ticks.
        login(5'd5, 1'b0);
        lc0 = lcCount;
        for (int i = 1; i <= 100; i++) begin
            sec_tick = 1'b1;
            activity = (i % 29 == 0);
            cycle();
            cycle();
        end
        checkVal("alive_100_en", game_enable, 1);
        checkVal("alive_100_tflag", timeout_flag, 0);
        checkVal("alive_100_lc", lcCount - lc0, 0);
        LoggedIn = 1'b0;
        cycle();
        cycle();

        // Random activity/tick mix against a consecutive-idle-seconds count.
        repeat (4) begin
            login(5'($urandom), 1'b0);
            we0 = weCount;
            lc0 = lcCount;
            c   = 0;
            for (int n = 0; n < 400; n++) begin
                activity = ($urandom % 40 == 0);
                sec_tick = 1'($urandom % 2);
                if (activity) c = 0;
                else if (sec_tick) c++;
                cycle();
                if (c == 30) break;
            end
            expTo = (c == 30);
            cycle();
            cycle();
            cycle();
            checkVal("rnd_tflag", timeout_flag, 32'(expTo));
            checkVal("rnd_logout", lcCount - lc0, 32'(expTo));
            checkVal("rnd_en", game_enable, 32'(!expTo));
            if (expTo) begin
                finishLogout();
            end else begin
                // Authenticator-side drop: straight to idle, no write, no logout pulse.
                LoggedIn = 1'b0;
                cycle();
                checkVal("drop_en", game_enable, 0);
                cycle();
                checkVal("drop_write", weCount - we0, 0);
                checkVal("drop_logout", lcCount - lc0, 0);
            end
        end

        // Withheld LoggedOut: LogoutCommand repeats every 16 cycles.
        login(5'd12, 1'b1);
        lc0 = lcCount;
        logout_button = 1'b1;
        cycle();
        cycle();
        k0 = lcTimes.size() - 1;
        t0 = lcTimes[k0];
        repeat ($urandom_range(40, 70)) cycle();
        tEnd = cycleNo + 1;
        nExp = (tEnd - 1 - t0) / 16 + 1;
        finishLogout();
        checkVal("retry_count", lcCount - lc0, nExp);
        for (int k = k0 + 1; k < lcTimes.size(); k++) begin
            checkVal("retry_period", lcTimes[k] - lcTimes[k-1], 16);
        end

        // Reset in SAVE suppresses the write; reset in LOGOUT suppresses the pulse.
        login(5'd21, 1'b0);
        we0 = weCount;
        lc0 = lcCount;
        score = 8'd77;
        logout_button = 1'b1;
        cycle();
        rst = 1'b1;
        LoggedIn = 1'b0;
        cycle();
        checkVal("rst_save_write", weCount - we0, 0);
        checkVal("rst_save_addr", score_addr, 0);
        checkVal("rst_save_wdata", score_wdata, 0);
        checkVal("rst_save_guest", session_guest, 0);
        checkVal("rst_save_en", game_enable, 0);
        rst = 1'b0;
        cycle();
        login(5'd22, 1'b1);
        logout_button = 1'b1;
        cycle();
        rst = 1'b1;
        LoggedIn = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        checkVal("rst_logout_pulse", lcCount - lc0, 0);
        checkVal("rst_logout_en", game_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
